// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one 128-bit state per handshake, COLS_PER_CYCLE
// columns transformed per clock through shared GF(2^8) row multipliers.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
);

    localparam int         N         = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_BEAT = 2'(N - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                       state_q, state_d;
    logic [1:0]                   beat_q;
    logic [127:0]                 blk_q;
    logic                         byp_q;
    logic                         accept;
    logic [32*COLS_PER_CYCLE-1:0] beat_res;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s  [4];
        logic [7:0] x9 [4];
        logic [7:0] xb [4];
        logic [7:0] xd [4];
        logic [7:0] xe [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            s[r]  = col[8*r +: 8];
            x2    = xtime(s[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            x9[r] = x8 ^ s[r];
            xb[r] = x8 ^ x2 ^ s[r];
            xd[r] = x8 ^ x4 ^ s[r];
            xe[r] = x8 ^ x4 ^ x2;
        end
        return {xb[0] ^ xd[1] ^ x9[2] ^ xe[3],
                xd[0] ^ x9[1] ^ xe[2] ^ xb[3],
                x9[0] ^ xe[1] ^ xb[2] ^ xd[3],
                xe[0] ^ xb[1] ^ xd[2] ^ x9[3]};
    endfunction

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = BUSY;
            end
            BUSY: begin
                if (beat_q == LAST_BEAT) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? BUSY : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // Columns handled on the current beat, selected from the latched block.
    always_comb begin
        logic [31:0] col;
        beat_res = '0;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            col = blk_q[32*(int'(beat_q)*COLS_PER_CYCLE + j) +: 32];
            beat_res[32*j +: 32] = byp_q ? col : inv_mix_col(col);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= 2'd0;
            blk_q    <= '0;
            byp_q    <= 1'b0;
            data_out <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                blk_q  <= data_in;
                byp_q  <= bypass;
                beat_q <= 2'd0;
            end else if (state_q == BUSY) begin
                beat_q <= beat_q + 2'd1;
                for (int j = 0; j < COLS_PER_CYCLE; j++)
                    data_out[32*(int'(beat_q)*COLS_PER_CYCLE + j) +: 32] <= beat_res[32*j +: 32];
            end
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// driven by directed and randomized tests against a matrix-form GF(2^8) model.
module tb_inv_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         bypass    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] data_in   [3];
    logic [127:0] data_out  [3];

    int errors = 0;
    int checks = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk      (clk),
                .rst      (rst),
                .in_valid (in_valid[g]),
                .in_ready (in_ready[g]),
                .data_in  (data_in[g]),
                .bypass   (bypass[g]),
                .out_valid(out_valid[g]),
                .out_ready(out_ready[g]),
                .data_out (data_out[g])
            );
        end
    endgenerate

    // Reference model: generic GF(2^8) product and the InvMixColumns matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        p  = 8'h00;
        aa = {1'b0, a};
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa ^= 9'h11b;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        if (byp) return d;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(d[32*c + 8*k +: 8], coef[(k - row + 4) % 4]);
                r[32*c + 8*row +: 8] = acc;
            end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input int u, input logic [127:0] d, input logic byp,
                             output logic [127:0] res, output int lat);
        @(negedge clk);
        in_valid[u]  = 1'b1;
        data_in[u]   = d;
        bypass[u]    = byp;
        out_ready[u] = 1'b0;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        data_in[u]  = rand128();
        bypass[u]   = ~byp;
        lat = -1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[u]) begin
                lat = i;
                break;
            end
        end
        res = data_out[u];
    endtask

    task automatic consume(input int u);
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            bypass[u]    = 1'b0;
            out_ready[u] = 1'b0;
            data_in[u]   = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || data_out[u] !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b data_out=%h, required 1 0 0",
                         u, in_ready[u], out_valid[u], data_out[u]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors(input int u);
        logic [31:0]  vin  [6];
        logic [31:0]  vout [6];
        logic [127:0] res, mixed;
        int           lat;
        vin  = '{32'hbca14d8e, 32'hf8bd7e4d, 32'h9d58dc9f, 32'hd6d7d5d5, 32'hc6c6c6c6, 32'h01010101};
        vout = '{32'h455313db, 32'h4c31262d, 32'h5c220af2, 32'hd5d4d4d4, 32'hc6c6c6c6, 32'h01010101};
        for (int v = 0; v < 6; v++) begin
            run_block(u, {4{vin[v]}}, 1'b0, res, lat);
            checks++;
            if (res !== {4{vout[v]}} || lat !== (4 >> u)) begin
                errors++;
                $display("FAIL vector[%0d] cpc=%0d: got %h lat %0d, required %h lat %0d",
                         v, 1 << u, res, lat, {4{vout[v]}}, 4 >> u);
            end
            consume(u);
        end
        mixed = {vin[0], vin[1], vin[2], vin[3]};
        run_block(u, mixed, 1'b0, res, lat);
        checks++;
        if (res !== model(mixed, 1'b0) || res !== {vout[0], vout[1], vout[2], vout[3]}) begin
            errors++;
            $display("FAIL mixed_cols cpc=%0d: got %h, required %h", 1 << u, res,
                     {vout[0], vout[1], vout[2], vout[3]});
        end
        consume(u);
    endtask

    task automatic test_bypass(input int u);
        logic [127:0] res;
        int           lat;
        run_block(u, 128'h0123456789abcdef0123456789abcdef, 1'b1, res, lat);
        checks++;
        if (res !== 128'h0123456789abcdef0123456789abcdef || lat !== (4 >> u)) begin
            errors++;
            $display("FAIL bypass cpc=%0d: got %h lat %0d, required unchanged lat %0d",
                     1 << u, res, lat, 4 >> u);
        end
        consume(u);
    endtask

    task automatic test_backpressure(input int u);
        logic [127:0] d1, d2, res;
        int           lat;
        d1 = rand128();
        d2 = rand128();
        run_block(u, d1, 1'b0, res, lat);
        checks++;
        if (res !== model(d1, 1'b0) || lat !== (4 >> u)) begin
            errors++;
            $display("FAIL bp_first cpc=%0d: got %h lat %0d, required %h", 1 << u, res, lat, model(d1, 1'b0));
        end
        in_valid[u] = 1'b1;
        data_in[u]  = d2;
        bypass[u]   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (data_out[u] !== model(d1, 1'b0) || out_valid[u] !== 1'b1 || in_ready[u] !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d] cpc=%0d: data %h ov %b ir %b", i, 1 << u,
                         data_out[u], out_valid[u], in_ready[u]);
            end
        end
        @(negedge clk);
        out_ready[u] = 1'b1;
        #1;
        checks++;
        if (in_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready cpc=%0d: in_ready=%b, required 1", 1 << u, in_ready[u]);
        end
        @(posedge clk);
        #1;
        out_ready[u] = 1'b0;
        in_valid[u]  = 1'b0;
        data_in[u]   = rand128();
        checks++;
        if (out_valid[u] !== 1'b0) begin
            errors++;
            $display("FAIL bp_consume cpc=%0d: out_valid=%b, required 0", 1 << u, out_valid[u]);
        end
        lat = -1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[u]) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (data_out[u] !== model(d2, 1'b0) || lat !== (4 >> u)) begin
            errors++;
            $display("FAIL bp_second cpc=%0d: got %h lat %0d, required %h lat %0d", 1 << u,
                     data_out[u], lat, model(d2, 1'b0), 4 >> u);
        end
        consume(u);
    endtask

    task automatic test_reset_mid(input int u);
        logic [127:0] d, res;
        int           lat;
        d = rand128();
        @(negedge clk);
        in_valid[u] = 1'b1;
        data_in[u]  = d;
        bypass[u]   = 1'b0;
        @(posedge clk);
        #1;
        in_valid[u] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1 || data_out[u] !== '0) begin
            errors++;
            $display("FAIL reset_mid cpc=%0d: ov %b ir %b data %h, required 0 1 0", 1 << u,
                     out_valid[u], in_ready[u], data_out[u]);
        end
        @(negedge clk);
        rst = 1'b0;
        d = rand128();
        run_block(u, d, 1'b0, res, lat);
        checks++;
        if (res !== model(d, 1'b0) || lat !== (4 >> u)) begin
            errors++;
            $display("FAIL after_reset cpc=%0d: got %h lat %0d, required %h", 1 << u, res, lat, model(d, 1'b0));
        end
        consume(u);
    endtask

    task automatic test_random(input int u, input int nblocks);
        logic [127:0] exp_q [$];
        logic [127:0] expv;
        int           sent = 0, received = 0, cyc = 0;
        logic         holding = 1'b0;
        while (received < nblocks && cyc < nblocks * 60) begin
            @(negedge clk);
            cyc++;
            if (!holding) begin
                in_valid[u] = (sent < nblocks) && ($urandom_range(3) != 0);
                data_in[u]  = rand128();
                bypass[u]   = ($urandom_range(7) == 0);
            end
            out_ready[u] = ($urandom_range(2) != 0);
            #1;
            if (in_valid[u] && in_ready[u]) begin
                exp_q.push_back(model(data_in[u], bypass[u]));
                sent++;
                holding = 1'b0;
            end else begin
                holding = in_valid[u];
            end
            if (out_valid[u] && out_ready[u]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_dup cpc=%0d: output %h with nothing outstanding", 1 << u, data_out[u]);
                end else begin
                    expv = exp_q.pop_front();
                    received++;
                    if (data_out[u] !== expv) begin
                        errors++;
                        $display("FAIL random_data cpc=%0d blk %0d: got %h, required %h", 1 << u,
                                 received, data_out[u], expv);
                    end
                end
            end
        end
        @(negedge clk);
        in_valid[u]  = 1'b0;
        out_ready[u] = 1'b0;
        checks++;
        if (received !== nblocks || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count cpc=%0d: received %0d of %0d, outstanding %0d", 1 << u,
                     received, nblocks, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        for (int u = 0; u < 3; u++) begin
            test_vectors(u);
            test_bypass(u);
            test_backpressure(u);
            test_reset_mid(u);
            test_random(u, 340);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
